// File: rtl/wb_memtest.sv
`default_nettype none
// wb_memtest: pipelined Wishbone master that writes seed^address over a word range,
// reads it back, and reports mismatch count, first failing address and bus error. Rev 1.0
module wb_memtest #(
  parameter int AW     = 15,
  parameter int DW     = 32,
  parameter int MAXOUT = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_start,
  input  logic [AW-1:0]   i_base,
  input  logic [AW-1:0]   i_len,
  input  logic [DW-1:0]   i_seed,
  output logic            o_busy,
  output logic            o_done,
  output logic [AW-1:0]   o_err_count,
  output logic            o_first_err_valid,
  output logic [AW-1:0]   o_first_err_addr,
  output logic            o_bus_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic [DW-1:0]   i_wb_data,
  input  logic            i_wb_err
);

  localparam int OW = $clog2(MAXOUT + 1);
  localparam logic [OW-1:0] MAXOUT_C = OW'(MAXOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_WDRAIN = 3'd2,
    S_GAP    = 3'd3,
    S_READ   = 3'd4,
    S_RDRAIN = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   len_q, len_d;
  logic [DW-1:0]   seed_q, seed_d;
  logic [AW-1:0]   issued_q, issued_d;
  logic [AW-1:0]   ackidx_q, ackidx_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [AW-1:0]   err_count_q, err_count_d;
  logic            first_err_valid_q, first_err_valid_d;
  logic [AW-1:0]   first_err_addr_q, first_err_addr_d;
  logic            bus_err_q, bus_err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;

  logic            accept;
  logic            ack_ok;
  logic [AW-1:0]   ack_addr;

  function automatic logic [DW-1:0] pattern(input logic [DW-1:0] seed, input logic [AW-1:0] a);
    return seed ^ DW'(a);
  endfunction

  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    len_d             = len_q;
    seed_d            = seed_q;
    issued_d          = issued_q;
    ackidx_d          = ackidx_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_addr_d  = first_err_addr_q;
    bus_err_d         = bus_err_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    cyc_d             = cyc_q;
    stb_d             = stb_q;
    we_d              = we_q;
    addr_d            = addr_q;
    data_d            = data_q;

    accept   = stb_q & ~i_wb_stall;
    // Acks with nothing outstanding are stray and must not disturb the counters.
    ack_ok   = cyc_q & i_wb_ack & (outst_q != '0);
    ack_addr = base_q + ackidx_q;
    outst_d  = outst_q + OW'(accept) - OW'(ack_ok);

    if (ack_ok && (state_q == S_READ || state_q == S_RDRAIN)) begin
      ackidx_d = ackidx_q + AW'(1);
      if (i_wb_data != pattern(seed_q, ack_addr)) begin
        err_count_d = err_count_q + AW'(1);
        if (!first_err_valid_q) begin
          first_err_valid_d = 1'b1;
          first_err_addr_d  = ack_addr;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d            = i_base;
          len_d             = i_len;
          seed_d            = i_seed;
          err_count_d       = '0;
          first_err_valid_d = 1'b0;
          first_err_addr_d  = '0;
          bus_err_d         = 1'b0;
          issued_d          = '0;
          ackidx_d          = '0;
          outst_d           = '0;
          if (i_len != '0) begin
            state_d = S_WRITE;
            busy_d  = 1'b1;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = i_base;
            data_d  = pattern(i_seed, i_base);
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_WRITE, S_READ: begin
        if (accept) issued_d = issued_q + AW'(1);
        if (issued_d == len_q) begin
          stb_d   = 1'b0;
          state_d = (state_q == S_WRITE) ? S_WDRAIN : S_RDRAIN;
        end else begin
          // Address only advances on acceptance, so it holds steady through a stall.
          stb_d  = (outst_d < MAXOUT_C);
          addr_d = base_q + issued_d;
          data_d = pattern(seed_q, base_q + issued_d);
        end
      end
      S_WDRAIN: begin
        if (outst_d == '0) begin
          cyc_d   = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d  = S_READ;
        issued_d = '0;
        ackidx_d = '0;
        cyc_d    = 1'b1;
        stb_d    = 1'b1;
        we_d     = 1'b0;
        addr_d   = base_q;
        data_d   = pattern(seed_q, base_q);
      end
      S_RDRAIN: begin
        if (outst_d == '0) begin
          cyc_d   = 1'b0;
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A bus error aborts whatever phase is running and skips straight to DONE.
    if (cyc_q && i_wb_err) begin
      bus_err_d = 1'b1;
      cyc_d     = 1'b0;
      stb_d     = 1'b0;
      we_d      = 1'b0;
      outst_d   = '0;
      state_d   = S_DONE;
      done_d    = 1'b1;
      busy_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q           <= S_IDLE;
      base_q            <= '0;
      len_q             <= '0;
      seed_q            <= '0;
      issued_q          <= '0;
      ackidx_q          <= '0;
      outst_q           <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_addr_q  <= '0;
      bus_err_q         <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      cyc_q             <= 1'b0;
      stb_q             <= 1'b0;
      we_q              <= 1'b0;
      addr_q            <= '0;
      data_q            <= '0;
    end else begin
      state_q           <= state_d;
      base_q            <= base_d;
      len_q             <= len_d;
      seed_q            <= seed_d;
      issued_q          <= issued_d;
      ackidx_q          <= ackidx_d;
      outst_q           <= outst_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_addr_q  <= first_err_addr_d;
      bus_err_q         <= bus_err_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      cyc_q             <= cyc_d;
      stb_q             <= stb_d;
      we_q              <= we_d;
      addr_q            <= addr_d;
      data_q            <= data_d;
    end
  end

  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_err_count       = err_count_q;
  assign o_first_err_valid = first_err_valid_q;
  assign o_first_err_addr  = first_err_addr_q;
  assign o_bus_err         = bus_err_q;
  assign o_wb_cyc          = cyc_q;
  assign o_wb_stb          = stb_q;
  assign o_wb_we           = we_q;
  assign o_wb_addr         = addr_q;
  assign o_wb_data         = data_q;
  assign o_wb_sel          = {(DW/8){cyc_q}};

endmodule
`default_nettype wire

// File: tb/tb_wb_memtest.sv
`default_nettype none
// tb_wb_memtest: directed bench for wb_memtest with a pipelined RAM slave model
// (optional stall, ack delay, read corruption and error injection). Rev 1.0
module tb_wb_memtest;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] base, len;
  logic [31:0] seed;

  logic        o_busy, o_done, o_first_err_valid, o_bus_err;
  logic [14:0] o_err_count, o_first_err_addr, o_wb_addr;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        wb_ack, wb_err, stall;
  logic [31:0] wb_rdata;

  int total = 0;
  int bad   = 0;

  wb_memtest #(.AW(15), .DW(32), .MAXOUT(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_base(base), .i_len(len),
    .i_seed(seed), .o_busy(o_busy), .o_done(o_done), .o_err_count(o_err_count),
    .o_first_err_valid(o_first_err_valid), .o_first_err_addr(o_first_err_addr),
    .o_bus_err(o_bus_err), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(wb_ack), .i_wb_stall(stall), .i_wb_data(wb_rdata), .i_wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic [31:0] mem [0:32767];
  logic [3:0]  sv, se;
  logic [31:0] sd [4];
  int          wcnt;
  int          dly = 1;
  int          err_at = 0;
  logic        stall_en = 1'b0;
  logic        corrupt_en = 1'b0;

  assign wb_ack   = sv[0];
  assign wb_err   = se[0];
  assign wb_rdata = sd[0];

  always @(posedge clk) begin
    if (!rst_n) begin
      sv <= '0; se <= '0; stall <= 1'b0; wcnt <= 0;
    end else begin
      stall <= stall_en ? ~stall : 1'b0;
      for (int i = 0; i < 3; i++) begin
        sv[i] <= sv[i+1]; se[i] <= se[i+1]; sd[i] <= sd[i+1];
      end
      sv[3] <= 1'b0; se[3] <= 1'b0;
      if (!o_busy) wcnt <= 0;
      if (o_wb_cyc && o_wb_stb && !stall) begin
        if (o_wb_we) begin
          mem[o_wb_addr] <= o_wb_data;
          wcnt <= wcnt + 1;
        end
        sv[dly-1] <= !(o_wb_we && err_at != 0 && wcnt + 1 == err_at);
        se[dly-1] <=  (o_wb_we && err_at != 0 && wcnt + 1 == err_at);
        sd[dly-1] <= mem[o_wb_addr] ^
                     {31'b0, corrupt_en && (o_wb_addr == 15'h13 || o_wb_addr == 15'h15)};
      end
    end
  end

  // ---------------- bus monitor (mid-cycle sampling) ----------------
  logic [14:0] log_addr [512];
  logic [31:0] log_data [512];
  logic        log_we   [512];
  int nlog = 0, outst_m = 0, max_out = 0, viol = 0, stall_hits = 0;
  int gapcnt = 0, errviol = 0, err_events = 0;
  logic        prev_hold = 1'b0, prev_err = 1'b0;
  logic [14:0] prev_addr;
  logic [31:0] prev_data;
  logic        acc, ak;

  assign acc = o_wb_cyc && o_wb_stb && !stall;
  assign ak  = o_wb_cyc && wb_ack && (outst_m > 0);

  always @(negedge clk) begin
    if (!rst_n) begin
      outst_m <= 0; prev_hold <= 1'b0; prev_err <= 1'b0;
    end else begin
      if (acc && nlog < 512) begin
        log_addr[nlog] <= o_wb_addr;
        log_data[nlog] <= o_wb_data;
        log_we[nlog]   <= o_wb_we;
        nlog <= nlog + 1;
      end
      outst_m <= outst_m + int'(acc) - int'(ak);
      if (outst_m + int'(acc) - int'(ak) > max_out) max_out <= outst_m + int'(acc) - int'(ak);
      if (prev_hold && !(o_wb_stb && o_wb_addr == prev_addr && o_wb_data == prev_data))
        viol <= viol + 1;
      prev_hold <= o_wb_cyc && o_wb_stb && stall;
      if (o_wb_cyc && o_wb_stb && stall) stall_hits <= stall_hits + 1;
      prev_addr <= o_wb_addr;
      prev_data <= o_wb_data;
      if (o_busy && !o_wb_cyc) gapcnt <= gapcnt + 1;
      if (prev_err && o_wb_cyc) errviol <= errviol + 1;
      if (wb_err && o_wb_cyc) err_events <= err_events + 1;
      prev_err <= wb_err && o_wb_cyc;
    end
  end

  // ---------------- checking and stimulus ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_test(input logic [14:0] b, input logic [14:0] l, input logic [31:0] s);
    @(negedge clk);
    base = b; len = l; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!o_done && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", o_done, 1'b1);
  endtask

  task automatic verify_log(input int ls, input logic [14:0] b, input int l, input logic [31:0] s);
    logic [14:0] a;
    check("log_count", nlog - ls, 2 * l);
    for (int k = 0; k < l; k++) begin
      a = b + 15'(k);
      check("wr_addr", log_addr[ls+k], a);
      check("wr_we", log_we[ls+k], 1'b1);
      check("wr_data", log_data[ls+k], s ^ {17'b0, a});
      check("rd_addr", log_addr[ls+l+k], a);
      check("rd_we", log_we[ls+l+k], 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {o_busy, o_done, o_err_count, o_first_err_valid, o_first_err_addr,
                          o_bus_err, o_wb_cyc, o_wb_stb, o_wb_we}, 64'd0);
    check({tag, "_bus"}, {o_wb_addr, o_wb_data, o_wb_sel}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

  initial begin
    int ls, gs, vs, hs, es, ev, lat, rd;
    rst_n = 1'b0; start = 1'b0; base = '0; len = '0; seed = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good memory
    ls = nlog; gs = gapcnt;
    start_test(15'h0010, 15'd8, 32'hA5A50000);
    check("busy_after_start", o_busy, 1'b1);
    wait_done(lat);
    check("latency_le_22", lat <= 22, 1'b1);
    check("busy_at_done", o_busy, 1'b0);
    verify_log(ls, 15'h0010, 8, 32'hA5A50000);
    check("good_first_data", log_data[ls], 32'hA5A50010);
    check("good_last_data", log_data[ls+7], 32'hA5A50017);
    check("good_gap_cycles", gapcnt - gs, 1);
    check("good_err_count", o_err_count, 15'd0);
    check("good_fev", o_first_err_valid, 1'b0);
    check("good_bus_err", o_bus_err, 1'b0);
    @(negedge clk);
    check("done_one_cycle", o_done, 1'b0);

    // Stall / backpressure, with an ignored start while busy
    stall_en = 1'b1; dly = 3;
    repeat (2) @(negedge clk);
    ls = nlog; vs = viol; hs = stall_hits;
    start_test(15'h0100, 15'd16, 32'h12345678);
    repeat (4) @(negedge clk);
    base = 15'h0200; len = 15'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    verify_log(ls, 15'h0100, 16, 32'h12345678);
    check("max_outstanding_le4", max_out <= 4, 1'b1);
    check("stall_seen", (stall_hits - hs) > 0, 1'b1);
    check("stable_in_stall", viol - vs, 0);
    check("stall_err_count", o_err_count, 15'd0);
    repeat (3) @(negedge clk);
    check("idle_after_stall", {o_busy, o_wb_cyc}, 2'b00);
    stall_en = 1'b0; dly = 1;
    repeat (4) @(negedge clk);

    // Corrupt read-back at 0x13 and 0x15
    corrupt_en = 1'b1;
    start_test(15'h0010, 15'd8, 32'hDEAD0000);
    wait_done(lat);
    check("corrupt_err_count", o_err_count, 15'd2);
    check("corrupt_fev", o_first_err_valid, 1'b1);
    check("corrupt_first_addr", o_first_err_addr, 15'h0013);
    corrupt_en = 1'b0;
    repeat (2) @(negedge clk);

    // Wrap-around at the top of the address space
    ls = nlog;
    start_test(15'h7FFE, 15'd4, 32'h0F0F0F0F);
    wait_done(lat);
    verify_log(ls, 15'h7FFE, 4, 32'h0F0F0F0F);
    check("wrap_third_addr", log_addr[ls+2], 15'h0000);
    check("wrap_rd_fourth", log_addr[ls+7], 15'h0001);
    check("wrap_err_count", o_err_count, 15'd0);
    repeat (2) @(negedge clk);

    // Bus error on the third write ack
    err_at = 3;
    ls = nlog; es = errviol; ev = err_events;
    start_test(15'h0040, 15'd8, 32'h00000000);
    wait_done(lat);
    check("buserr_flag", o_bus_err, 1'b1);
    check("buserr_cyc_low", o_wb_cyc, 1'b0);
    check("buserr_events", err_events - ev, 1);
    check("buserr_cyc_drop", errviol - es, 0);
    check("buserr_third_addr", log_addr[ls+2], 15'h0042);
    repeat (5) @(negedge clk);
    rd = 0;
    for (int k = ls; k < nlog; k++) if (!log_we[k]) rd++;
    check("buserr_no_read_stb", rd, 0);
    err_at = 0;

    // Empty test: done on the next cycle, no bus activity, results cleared
    ls = nlog;
    start_test(15'h0010, 15'd0, 32'hFFFFFFFF);
    check("len0_done", o_done, 1'b1);
    check("len0_cyc", {o_wb_cyc, o_busy}, 2'b00);
    check("len0_cleared", {o_err_count, o_first_err_valid, o_bus_err}, 17'd0);
    repeat (3) @(negedge clk);
    check("len0_no_requests", nlog - ls, 0);

    // Asynchronous reset in the middle of the read phase
    start_test(15'h0020, 15'd8, 32'h55AA0000);
    lat = 0;
    while (!(o_wb_cyc && !o_wb_we) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("reached_read", {o_wb_cyc, o_wb_we}, 2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal run after reset release
    ls = nlog;
    start_test(15'h0030, 15'd4, 32'h11110000);
    wait_done(lat);
    verify_log(ls, 15'h0030, 4, 32'h11110000);
    check("post_reset_err", {o_err_count, o_first_err_valid, o_bus_err}, 17'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
